// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply sequencer: FSM encoding and the
// default multiplier latency used by the pipeline stall logic and the multiplier.
package mul_hilo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Clock edges from the mul_st-high edge until the multiplier product is final.
    localparam int MUL_LATENCY_DEF = 33;

endpackage

// File: rtl/mul_hilo_ctrl_if.sv
// Pipeline-side and multiplier-side signals of the HI/LO multiply sequencer.
// Handshake: req is taken on a rising edge only while the sequencer is not busy.
interface mul_hilo_ctrl_if
    import mul_hilo_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic               req;
    logic               req_signed;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               busy;
    logic               done;
    logic               mthi;
    logic               mtlo;
    logic [WIDTH-1:0]   wr_data;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic               mul_st;
    logic [2*WIDTH-1:0] mul_product;
    state_t             state;

    modport master (
        output req, req_signed, op_a, op_b, mthi, mtlo, wr_data, mul_product,
        input  busy, done, hi, lo, mul_a, mul_b, mul_st, state
    );

    modport slave (
        input  req, req_signed, op_a, op_b, mthi, mtlo, wr_data, mul_product,
        output busy, done, hi, lo, mul_a, mul_b, mul_st, state
    );
endinterface

// File: rtl/mul_hilo_ctrl_counter.sv
// Latency counter for the multiply sequencer: synchronous clear, count enable,
// and a terminal-count flag raised while the count equals MUL_LATENCY-1.
module mul_latency_counter #(
    parameter int MUL_LATENCY = 33
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int CW = $clog2(MUL_LATENCY + 1);

    logic [CW-1:0] count;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == CW'(MUL_LATENCY - 1));
endmodule

// File: rtl/mul_hilo_ctrl.sv
// HI/LO register file and sequencer for an external fixed-latency multiplier.
// Optional signed multiply via magnitude/negate is enabled by SIGNED_MULT_EN.
module mul_hilo_ctrl
    import mul_hilo_ctrl_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic           Clk,
    input  logic           Reset,
    mul_hilo_ctrl_if.slave bus
);
    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               tc;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic [WIDTH-1:0]   load_a;
    logic [WIDTH-1:0]   load_b;
    logic [2*WIDTH-1:0] result;

    assign accept = bus.req && ((state == IDLE) || (state == DONE));

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = START;
            START:   state_next = WAIT;
            WAIT:    if (tc) state_next = DONE;
            DONE:    state_next = accept ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    mul_latency_counter #(
        .MUL_LATENCY (MUL_LATENCY)
    ) u_counter (
        .Clk    (Clk),
        .Reset  (Reset),
        .clear  (state == START),
        .enable (state == WAIT),
        .tc     (tc)
    );

`ifdef SIGNED_MULT_EN
    logic neg;
    logic neg_next;

    // Signed requests send magnitudes to the unsigned multiplier; the sign is reapplied at capture.
    always_comb begin
        load_a   = (bus.req_signed && bus.op_a[WIDTH-1]) ? (~bus.op_a + WIDTH'(1)) : bus.op_a;
        load_b   = (bus.req_signed && bus.op_b[WIDTH-1]) ? (~bus.op_b + WIDTH'(1)) : bus.op_b;
        neg_next = bus.req_signed && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
        result   = neg ? (~bus.mul_product + (2*WIDTH)'(1)) : bus.mul_product;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            neg <= 1'b0;
        end else if (accept) begin
            neg <= neg_next;
        end
    end
`else
    logic unused_req_signed;

    always_comb begin
        load_a            = bus.op_a;
        load_b            = bus.op_b;
        result            = bus.mul_product;
        unused_req_signed = bus.req_signed;
    end
`endif

    // Capture only happens in WAIT, where writes are gated off, so the two never collide.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            hi    <= '0;
            lo    <= '0;
            mul_a <= '0;
            mul_b <= '0;
        end else begin
            if (accept) begin
                mul_a <= load_a;
                mul_b <= load_b;
            end
            if ((state != START) && (state != WAIT)) begin
                if (bus.mthi) hi <= bus.wr_data;
                if (bus.mtlo) lo <= bus.wr_data;
            end
            if ((state == WAIT) && tc) begin
                hi <= result[2*WIDTH-1:WIDTH];
                lo <= result[WIDTH-1:0];
            end
        end
    end

    assign bus.busy   = (state == START) || (state == WAIT);
    assign bus.done   = (state == DONE);
    assign bus.mul_st = (state == START);
    assign bus.hi     = hi;
    assign bus.lo     = lo;
    assign bus.mul_a  = mul_a;
    assign bus.mul_b  = mul_b;
    assign bus.state  = state;
endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl with a behavioural fixed-latency multiplier
// that only presents a valid product once its latency has elapsed.
module tb_mul_hilo_ctrl;
    import mul_hilo_ctrl_pkg::*;

    localparam int W   = 16;
    localparam int LAT = MUL_LATENCY_DEF;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mul_hilo_ctrl_if #(.WIDTH(W)) bus ();

    mul_hilo_ctrl #(
        .WIDTH       (W),
        .MUL_LATENCY (LAT)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: latches operands on mul_st, product valid LAT edges later.
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic         m_active;
    int           m_cnt;

    always @(posedge clk) begin
        if (!rst) begin
            m_active <= 1'b0;
            m_cnt    <= 0;
        end else if (bus.mul_st) begin
            m_a      <= bus.mul_a;
            m_b      <= bus.mul_b;
            m_active <= 1'b1;
            m_cnt    <= 0;
        end else if (m_active && m_cnt < LAT) begin
            m_cnt <= m_cnt + 1;
        end
    end

    assign bus.mul_product = (m_active && m_cnt >= LAT - 1) ?
                             ({16'h0, m_a} * {16'h0, m_b}) : 32'hDEAD_BEEF;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Steps until done is seen; cyc is the number of edges taken, -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (bus.done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        bus.req        = 1'b1;
        bus.op_a       = a;
        bus.op_b       = b;
        bus.req_signed = sgn;
        step();
        bus.req        = 1'b0;
        bus.req_signed = 1'b0;
    endtask

    int cyc;
    int busy_cnt;
    int done_cnt;
    int done_at;
    int hold_err;

    initial begin
        rst            = 1'b0;
        bus.req        = 1'b0;
        bus.req_signed = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;
        bus.mthi       = 1'b0;
        bus.mtlo       = 1'b0;
        bus.wr_data    = '0;
        step();
        step();
        check("rst_hi",    32'(bus.hi),     32'h0);
        check("rst_lo",    32'(bus.lo),     32'h0);
        check("rst_busy",  32'(bus.busy),   32'h0);
        check("rst_done",  32'(bus.done),   32'h0);
        check("rst_mulst", 32'(bus.mul_st), 32'h0);
        check("rst_mula",  32'(bus.mul_a),  32'h0);
        check("rst_state", 32'(bus.state),  32'(IDLE));
        rst = 1'b1;
        step();

        // Unsigned 0x1234 * 0x5678 with a gated mthi mid-operation.
        issue(16'h1234, 16'h5678, 1'b0);
        check("t1_start_busy",  32'(bus.busy),   32'h1);
        check("t1_start_mulst", 32'(bus.mul_st), 32'h1);
        check("t1_mula",        32'(bus.mul_a),  32'h1234);
        check("t1_mulb",        32'(bus.mul_b),  32'h5678);
        bus.mthi    = 1'b1;
        bus.wr_data = 16'hAAAA;
        step();
        bus.mthi = 1'b0;
        check("t1_mthi_gated", 32'(bus.hi),     32'h0);
        check("t1_wait_busy",  32'(bus.busy),   32'h1);
        check("t1_wait_mulst", 32'(bus.mul_st), 32'h0);
        busy_cnt = 2;
        done_cnt = 0;
        done_at  = 0;
        hold_err = 0;
        for (int k = 3; k <= 37; k++) begin
            step();
            if (bus.busy) begin
                busy_cnt++;
                if (bus.mul_a !== 16'h1234 || bus.mul_b !== 16'h5678) hold_err++;
            end
            if (bus.done) begin
                done_cnt++;
                done_at = k;
            end
            if (k == 35) begin
                check("t1_hi", 32'(bus.hi), 32'h0626);
                check("t1_lo", 32'(bus.lo), 32'h0060);
            end
        end
        check("t1_busy_cycles", 32'(busy_cnt), 32'd34);
        check("t1_done_count",  32'(done_cnt), 32'd1);
        check("t1_done_at",     32'(done_at),  32'd35);
        check("t1_operand_hold", 32'(hold_err), 32'd0);
        check("t1_idle_state",  32'(bus.state), 32'(IDLE));

        // mtlo while idle, then both registers in one write.
        bus.mtlo    = 1'b1;
        bus.wr_data = 16'h5555;
        step();
        bus.mtlo = 1'b0;
        check("mtlo_idle_lo", 32'(bus.lo), 32'h5555);
        check("mtlo_idle_hi", 32'(bus.hi), 32'h0626);
        bus.mthi    = 1'b1;
        bus.mtlo    = 1'b1;
        bus.wr_data = 16'h7777;
        step();
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check("mt_both_hi", 32'(bus.hi), 32'h7777);
        check("mt_both_lo", 32'(bus.lo), 32'h7777);

        // Back-to-back: second request held through busy, taken in the DONE cycle.
        bus.req  = 1'b1;
        bus.op_a = 16'h0003;
        bus.op_b = 16'h0005;
        step();
        bus.op_a = 16'hFFFF;
        bus.op_b = 16'hFFFF;
        step();
        check("b2b_ignored_req", 32'(bus.mul_a), 32'h0003);
        wait_done(cyc);
        check("b2b_first_done", 32'(cyc), 32'd33);
        check("b2b_first_lo",   32'(bus.lo), 32'h000F);
        check("b2b_first_hi",   32'(bus.hi), 32'h0000);
        step();
        bus.req = 1'b0;
        check("b2b_no_gap_busy", 32'(bus.busy),   32'h1);
        check("b2b_no_gap_st",   32'(bus.mul_st), 32'h1);
        check("b2b_second_mula", 32'(bus.mul_a),  32'hFFFF);
        wait_done(cyc);
        check("b2b_second_done", 32'(cyc), 32'd34);
        check("b2b_hi", 32'(bus.hi), 32'hFFFE);
        check("b2b_lo", 32'(bus.lo), 32'h0001);

        // Reset during WAIT abandons the operation.
        issue(16'h00FF, 16'h0101, 1'b0);
        for (int i = 0; i < 9; i++) step();
        check("rmid_in_wait", 32'(bus.state), 32'(WAIT));
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("rmid_hi",    32'(bus.hi),     32'h0);
        check("rmid_lo",    32'(bus.lo),     32'h0);
        check("rmid_busy",  32'(bus.busy),   32'h0);
        check("rmid_mulst", 32'(bus.mul_st), 32'h0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.done) done_cnt++;
        end
        check("rmid_no_done", 32'(done_cnt), 32'd0);
        check("rmid_lo_kept", 32'(bus.lo),   32'h0);
        issue(16'h0003, 16'h0004, 1'b0);
        wait_done(cyc);
        check("rmid_after_done", 32'(cyc), 32'd34);
        check("rmid_after_lo",   32'(bus.lo), 32'h000C);
        check("rmid_after_hi",   32'(bus.hi), 32'h0000);
        step();

        // mtlo together with a request from idle.
        bus.mtlo    = 1'b1;
        bus.wr_data = 16'h1111;
        issue(16'h0002, 16'h0002, 1'b0);
        bus.mtlo = 1'b0;
        check("sim_lo_write", 32'(bus.lo),   32'h1111);
        check("sim_busy",     32'(bus.busy), 32'h1);
        wait_done(cyc);
        check("sim_done", 32'(cyc), 32'd34);
        check("sim_lo",   32'(bus.lo), 32'h0004);
        check("sim_hi",   32'(bus.hi), 32'h0000);
        step();

`ifdef SIGNED_MULT_EN
        issue(16'hFFFE, 16'h0003, 1'b1);
        check("s1_mula", 32'(bus.mul_a), 32'h0002);
        check("s1_mulb", 32'(bus.mul_b), 32'h0003);
        wait_done(cyc);
        check("s1_done", 32'(cyc), 32'd34);
        check("s1_prod", {bus.hi, bus.lo}, 32'hFFFF_FFFA);
        step();
        issue(16'h8000, 16'h8000, 1'b1);
        check("s2_mula", 32'(bus.mul_a), 32'h8000);
        wait_done(cyc);
        check("s2_prod", {bus.hi, bus.lo}, 32'h4000_0000);
        step();
        issue(16'hFFFE, 16'h0003, 1'b0);
        wait_done(cyc);
        check("s3_unsigned_prod", {bus.hi, bus.lo}, 32'h0002_FFFA);
        step();
`else
        issue(16'hFFFE, 16'h0003, 1'b1);
        check("u_sgn_ignored_mula", 32'(bus.mul_a), 32'hFFFE);
        wait_done(cyc);
        check("u_sgn_ignored_prod", {bus.hi, bus.lo}, 32'h0002_FFFA);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
